// File: rtl/fb_write_scheduler_pkg.sv
// fb_pkg: screen geometry, address width, colour and FSM state types
// shared by the frame-buffer write scheduler and its testbench.
package fb_pkg;

   localparam int H_RES    = 800;
   localparam int V_RES    = 525;
   localparam int FB_DEPTH = H_RES * V_RES;
   localparam int ADDR_W   = 21;

   typedef logic [1:0] color_t;

   typedef enum logic [1:0] {
      IDLE,
      STAMP,
      CLEAR
   } fbw_state_t;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// fb_write_scheduler_if: brush request handshake, clear request/busy and
// frame-buffer write strobe. master = requester side, slave = scheduler.
interface fb_write_scheduler_if;
   import fb_pkg::*;

   logic              clear_req;
   logic              clear_busy;
   logic              dot_valid;
   logic              dot_ready;
   logic [9:0]        dot_x;
   logic [9:0]        dot_y;
   color_t            dot_color;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   color_t            wr_data;

   modport master (
      output clear_req, dot_valid, dot_x, dot_y, dot_color,
      input  clear_busy, dot_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  clear_req, dot_valid, dot_x, dot_y, dot_color,
      output clear_busy, dot_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/fb_write_scheduler_brush_scan.sv
// brush_scan: walks dy=-R..R (outer), dx=-R..R (inner), one offset per cycle.
// Ports: start/cx/cy in; offset_valid, in_bounds, px, py, row_last, last out.
module brush_scan #(
   parameter int H_RES = 800,
   parameter int V_RES = 525,
   parameter int BRUSH = 3
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               start,
   input  logic [9:0]         cx,
   input  logic [9:0]         cy,
   output logic               offset_valid,
   output logic               in_bounds,
   output logic signed [10:0] px,
   output logic signed [10:0] py,
   output logic               row_last,
   output logic               last
);

   localparam logic signed [10:0] RAD  = 11'((BRUSH - 1) / 2);
   localparam logic signed [10:0] HLIM = 11'(H_RES);
   localparam logic signed [10:0] VLIM = 11'(V_RES);

   logic               active;
   logic signed [10:0] dx;
   logic signed [10:0] dy;
   logic [9:0]         cx_q;
   logic [9:0]         cy_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         active <= 1'b0;
         dx     <= '0;
         dy     <= '0;
         cx_q   <= '0;
         cy_q   <= '0;
      end else if (start) begin
         active <= 1'b1;
         dx     <= -RAD;
         dy     <= -RAD;
         cx_q   <= cx;
         cy_q   <= cy;
      end else if (active) begin
         if (row_last) begin
            dx <= -RAD;
            if (last) active <= 1'b0;
            else      dy     <= dy + 11'sd1;
         end else begin
            dx <= dx + 11'sd1;
         end
      end
   end

   // 11-bit signed so a centre at 0 yields -R instead of wrapping
   assign px           = $signed({1'b0, cx_q}) + dx;
   assign py           = $signed({1'b0, cy_q}) + dy;
   assign offset_valid = active;
   assign row_last     = active && (dx == RAD);
   assign last         = row_last && (dy == RAD);
   assign in_bounds    = (px >= 11'sd0) && (px < HLIM) &&
                         (py >= 11'sd0) && (py < VLIM);

endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: arbitrates the frame-buffer write port between brush
// stamps and full-screen clears. Ports: Clk, Reset_n, bus (slave modport).
module fb_write_scheduler #(
   parameter int H_RES          = fb_pkg::H_RES,
   parameter int V_RES          = fb_pkg::V_RES,
   parameter int BRUSH          = 3,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   fb_write_scheduler_if.slave  bus
);
   import fb_pkg::*;

   localparam int AW1 = ADDR_W + 1;
   localparam int R   = (BRUSH - 1) / 2;

   localparam logic signed [ADDR_W:0] HSTEP    = AW1'(H_RES);
   localparam logic signed [ADDR_W:0] RBIAS    = AW1'(R * H_RES);
   localparam logic signed [ADDR_W:0] LAST_ROW = AW1'((V_RES - 1) * H_RES);
   localparam logic [9:0]             LAST_COL = 10'(H_RES - 1);

   fbw_state_t state;
   fbw_state_t state_nxt;

   logic                     clear_pend;
   logic signed [ADDR_W:0]   row_base;
   logic [9:0]               col;
   color_t                   color;
   logic                     accept;
   logic                     go_clear;
   logic                     clr_last;

   logic                     scan_valid;
   logic                     scan_inb;
   logic                     scan_row_last;
   logic                     scan_last;
   logic signed [10:0]       scan_px;
   logic signed [10:0]       scan_py;
   logic                     unused_py;

   logic                     wr_en_d;
   logic [ADDR_W-1:0]        wr_addr_d;
   color_t                   wr_data_d;
   logic                     wr_en_q;
   logic [ADDR_W-1:0]        wr_addr_q;
   color_t                   wr_data_q;

   logic signed [ADDR_W:0]   y_ext;
   logic signed [ADDR_W:0]   px_ext;

   assign accept   = (state == IDLE) && !clear_pend && bus.dot_valid;
   assign go_clear = (state == IDLE) && clear_pend;
   assign clr_last = (col == LAST_COL) && (row_base == LAST_ROW);

   assign bus.dot_ready  = (state == IDLE) && !clear_pend;
   assign bus.clear_busy = clear_pend || (state == CLEAR);
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;

   assign y_ext     = AW1'($signed({1'b0, bus.dot_y}));
   assign px_ext    = AW1'(scan_px);
   assign unused_py = ^scan_py;

   brush_scan #(
      .H_RES (H_RES),
      .V_RES (V_RES),
      .BRUSH (BRUSH)
   ) u_scan (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .start        (accept),
      .cx           (bus.dot_x),
      .cy           (bus.dot_y),
      .offset_valid (scan_valid),
      .in_bounds    (scan_inb),
      .px           (scan_px),
      .py           (scan_py),
      .row_last     (scan_row_last),
      .last         (scan_last)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (go_clear)    state_nxt = CLEAR;
            else if (accept) state_nxt = STAMP;
         end
         STAMP:   if (scan_last) state_nxt = IDLE;
         CLEAR:   if (clr_last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Address and data hold their last value on idle slots
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      unique case (1'b1)
         (state == STAMP) && scan_valid && scan_inb: begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(row_base + px_ext);
            wr_data_d = color;
         end
         (state == CLEAR): begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(row_base + AW1'(col));
            wr_data_d = 2'b00;
         end
         default: ;
      endcase
   end

   // row_base is shared: stamp rows (may start negative) or clear rows
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         clear_pend <= (CLEAR_ON_RESET != 0);
         row_base   <= '0;
         col        <= '0;
         color      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         if (go_clear)
            clear_pend <= 1'b0;
         else if (bus.clear_req && (state != CLEAR))
            clear_pend <= 1'b1;
         unique case (1'b1)
            accept: begin
               row_base <= y_ext * HSTEP - RBIAS;
               color    <= bus.dot_color;
            end
            go_clear: begin
               row_base <= '0;
               col      <= '0;
            end
            (state == STAMP) && scan_row_last:
               row_base <= row_base + HSTEP;
            (state == CLEAR): begin
               if (col == LAST_COL) begin
                  col      <= '0;
                  row_base <= row_base + HSTEP;
               end else begin
                  col <= col + 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: random and directed brush/clear traffic against a
// screen-level model; reduced screen keeps full sweeps short.
module tb_fb_write_scheduler;
   import fb_pkg::*;

   localparam int H  = 120;
   localparam int V  = 60;
   localparam int B  = 3;
   localparam int R  = (B - 1) / 2;
   localparam int FB = H * V;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;

   fb_write_scheduler_if bus();

   fb_write_scheduler #(
      .H_RES          (H),
      .V_RES          (V),
      .BRUSH          (B),
      .CLEAR_ON_RESET (1)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   int n_tests   = 0;
   int n_fail    = 0;
   int oob       = 0;
   int last_data = 0;
   int model_mem [FB];
   int dut_mem   [FB];

   always @(negedge Clk) begin
      if (bus.wr_en === 1'b1) begin
         if (bus.wr_addr < FB) dut_mem[bus.wr_addr] = int'(bus.wr_data);
         else                  oob++;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Caller positions at the cycle where address 0 should be visible
   task automatic run_sweep(input string tag, input int stop_at);
      int b_en = 0, b_addr = 0, b_data = 0, b_busy = 0, b_rdy = 0;
      int last_i = 0;
      for (int i = 0; i < FB; i++) begin
         if (i > 0) tick();
         last_i = i;
         if (bus.wr_en !== 1'b1) b_en++;
         if (int'(bus.wr_addr) !== i) b_addr++;
         if (bus.wr_data !== 2'b00) b_data++;
         if (i <= FB - 2 && bus.clear_busy !== 1'b1) b_busy++;
         if (i <= FB - 2 && bus.dot_ready !== 1'b0) b_rdy++;
         model_mem[i] = 0;
         if (i == stop_at) break;
      end
      last_data = 0;
      chk({tag, " en"}, b_en, 0);
      chk({tag, " addr"}, b_addr, 0);
      chk({tag, " data"}, b_data, 0);
      chk({tag, " busy"}, b_busy, 0);
      chk({tag, " ready"}, b_rdy, 0);
      if (last_i == FB - 1) begin
         chk({tag, " last addr"}, int'(bus.wr_addr), FB - 1);
         tick();
         chk({tag, " busy end"}, bus.clear_busy, 0);
         chk({tag, " ready end"}, bus.dot_ready, 1);
         chk({tag, " en end"}, bus.wr_en, 0);
      end
   endtask

   task automatic do_dot(input int x, input int y, input int c,
                         input bit clr_mid);
      int n = 0;
      int slot = 0;
      while (bus.dot_ready !== 1'b1 && n < 30000) begin
         tick();
         n++;
      end
      chk("dot wait timeout", int'(n >= 30000), 0);
      bus.dot_valid = 1'b1;
      bus.dot_x     = 10'(x);
      bus.dot_y     = 10'(y);
      bus.dot_color = 2'(c);
      tick();
      if (!clr_mid) bus.dot_valid = 1'b0;
      chk("ready after accept", bus.dot_ready, 0);
      for (int dy = -R; dy <= R; dy++) begin
         for (int dx = -R; dx <= R; dx++) begin
            int px = x + dx;
            int py = y + dy;
            int inb = (px >= 0 && px < H && py >= 0 && py < V) ? 1 : 0;
            tick();
            if (clr_mid && slot == 2) bus.clear_req = 1'b0;
            chk("stamp en", bus.wr_en, inb);
            if (inb == 1) begin
               chk("stamp addr", int'(bus.wr_addr), py * H + px);
               chk("stamp data", int'(bus.wr_data), c);
               model_mem[py * H + px] = c;
               last_data = c;
            end else begin
               chk("held data", int'(bus.wr_data), last_data);
            end
            chk("stamp ready", bus.dot_ready,
                (slot == B * B - 1 && !clr_mid) ? 1 : 0);
            if (clr_mid && slot == 1) bus.clear_req = 1'b1;
            slot++;
         end
      end
   endtask

   function automatic int rnd_coord(input int lim);
      int sel = int'($urandom_range(0, 3));
      if (sel == 0) return 0;
      if (sel == 1) return lim - 1;
      return int'($urandom_range(0, lim - 1));
   endfunction

   initial begin
      int diff = 0;
      bus.clear_req = 1'b0;
      bus.dot_valid = 1'b0;
      bus.dot_x     = '0;
      bus.dot_y     = '0;
      bus.dot_color = '0;
      for (int i = 0; i < FB; i++) begin
         model_mem[i] = 3;
         dut_mem[i]   = 3;
      end

      Reset_n = 1'b0;
      repeat (3) tick();
      chk("rst wr_en", bus.wr_en, 0);
      chk("rst wr_addr", int'(bus.wr_addr), 0);
      chk("rst wr_data", int'(bus.wr_data), 0);
      chk("rst busy", bus.clear_busy, 1);
      chk("rst ready", bus.dot_ready, 0);
      Reset_n = 1'b1;
      tick();
      chk("por gap", bus.wr_en, 0);
      tick();
      run_sweep("por", FB);

      do_dot(100, 50, 2, 1'b0);
      do_dot(0, 0, 1, 1'b0);
      do_dot(H - 1, V - 1, 3, 1'b0);
      repeat (40)
         do_dot(rnd_coord(H), rnd_coord(V), int'($urandom_range(0, 3)), 1'b0);

      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      chk("req busy", bus.clear_busy, 1);
      chk("req ready", bus.dot_ready, 0);
      tick();
      chk("req gap", bus.wr_en, 0);
      tick();
      run_sweep("clr", FB);

      do_dot(60, 30, 1, 1'b1);
      tick();
      chk("mid gap en", bus.wr_en, 0);
      chk("mid gap ready", bus.dot_ready, 0);
      tick();
      bus.dot_valid = 1'b0;
      run_sweep("clr mid", FB);

      repeat (10)
         do_dot(rnd_coord(H), rnd_coord(V), int'($urandom_range(1, 3)), 1'b0);

      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      tick();
      tick();
      run_sweep("pre rst", 1000);
      Reset_n = 1'b0;
      #1;
      chk("abort wr_en", bus.wr_en, 0);
      chk("abort wr_addr", int'(bus.wr_addr), 0);
      chk("abort wr_data", int'(bus.wr_data), 0);
      tick();
      chk("abort busy", bus.clear_busy, 1);
      Reset_n = 1'b1;
      tick();
      chk("restart gap", bus.wr_en, 0);
      tick();
      run_sweep("restart", FB);

      do_dot(0, V - 1, 2, 1'b0);
      do_dot(H - 1, 0, 1, 1'b0);
      repeat (10)
         do_dot(rnd_coord(H), rnd_coord(V), int'($urandom_range(0, 3)), 1'b0);
      tick();

      for (int i = 0; i < FB; i++)
         if (model_mem[i] != dut_mem[i]) diff++;
      chk("screen image", diff, 0);
      chk("out of range writes", oob, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
